// File: rtl/dac_segment_sequencer.sv
// Segment-list player: BRAM port B reads -> registered dual 14-bit DAC samples.
// Optional DAC_SEQ_LOOPCNT_EN adds loop_cnt_o, a saturating count of list passes.
module dac_segment_sequencer #(
  parameter int ADDR_WIDTH = 11,
  parameter int NUM_SEG    = 4,
  parameter int REP_WIDTH  = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         seq_en_i,
  input  logic                         seq_loop_i,
  input  logic                         desc_we_i,
  input  logic [$clog2(NUM_SEG)-1:0]   desc_idx_i,
  input  logic [ADDR_WIDTH-1:0]        desc_start_i,
  input  logic [ADDR_WIDTH-1:0]        desc_len_i,
  input  logic [REP_WIDTH-1:0]         desc_rep_i,
  input  logic [$clog2(NUM_SEG):0]     desc_nseg_i,
  input  logic                         desc_commit_i,
  output logic                         commit_pend_o,
  output logic [ADDR_WIDTH-1:0]        mem_addr_o,
  output logic                         mem_rd_en_o,
  input  logic [31:0]                  mem_data_i,
  output logic [13:0]                  dac_ch0_o,
  output logic [13:0]                  dac_ch1_o,
  output logic                         dac_valid_o,
  output logic [$clog2(NUM_SEG)-1:0]   seg_idx_o,
  output logic                         seq_busy_o,
`ifdef DAC_SEQ_LOOPCNT_EN
  output logic [15:0]                  loop_cnt_o,
`endif
  output logic                         seq_done_o
);
  localparam int SW = $clog2(NUM_SEG);
  localparam int NW = SW + 1;

  typedef struct packed {
    logic [1:0]  rsv1;
    logic [13:0] ch1;
    logic [1:0]  rsv0;
    logic [13:0] ch0;
  } dac_sample_t;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e state_q, state_d;

  logic [ADDR_WIDTH-1:0] sh_start_q [NUM_SEG];
  logic [ADDR_WIDTH-1:0] sh_len_q   [NUM_SEG];
  logic [REP_WIDTH-1:0]  sh_rep_q   [NUM_SEG];
  logic [NW-1:0]         sh_nseg_q;
  logic [ADDR_WIDTH-1:0] act_start_q [NUM_SEG];
  logic [ADDR_WIDTH-1:0] act_len_q   [NUM_SEG];
  logic [REP_WIDTH-1:0]  act_rep_q   [NUM_SEG];
  logic [NW-1:0]         act_nseg_q;

  logic                  pend_q, pend_d;
  logic [SW-1:0]         seg_q, seg_d;
  logic [REP_WIDTH-1:0]  rep_q, rep_d;
  logic [ADDR_WIDTH-1:0] off_q, off_d;
  logic                  done_q, done_d;
  logic                  v1_q;
  logic                  vld_q;
  logic [13:0]           ch0_q, ch1_q;

  logic [ADDR_WIDTH-1:0] cur_start, cur_len;
  logic [REP_WIDTH-1:0]  cur_rep;
  logic [NW-1:0]         nseg_clamp;
  logic                  run, rd_go, last_samp, last_rep, last_seg;
  logic                  list_end, apply;
  dac_sample_t           smp;

  assign cur_start  = act_start_q[seg_q];
  assign cur_len    = act_len_q[seg_q];
  assign cur_rep    = act_rep_q[seg_q];
  assign nseg_clamp = (desc_nseg_i > NW'(NUM_SEG)) ? NW'(NUM_SEG) : desc_nseg_i;
  assign run        = (state_q == RUN);
  assign rd_go      = run && seq_en_i && (act_nseg_q != '0);
  assign last_samp  = (cur_len == '0) || (off_q == cur_len - ADDR_WIDTH'(1));
  assign last_rep   = (rep_q == cur_rep);
  assign last_seg   = ({1'b0, seg_q} == act_nseg_q - NW'(1));
  assign list_end   = rd_go && last_samp && last_rep && last_seg;
  // In RUN the bank swap waits for the list boundary so the next read sees it
  assign apply      = pend_q && (!run || list_end);
  assign pend_d     = (pend_q && !apply) || desc_commit_i;
  assign smp        = dac_sample_t'(mem_data_i);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_SEG; i++) begin
        sh_start_q[i]  <= '0;
        sh_len_q[i]    <= '0;
        sh_rep_q[i]    <= '0;
        act_start_q[i] <= '0;
        act_len_q[i]   <= '0;
        act_rep_q[i]   <= '0;
      end
      sh_nseg_q  <= '0;
      act_nseg_q <= '0;
      pend_q     <= 1'b0;
    end else begin
      if (desc_we_i) begin
        sh_start_q[desc_idx_i] <= desc_start_i;
        sh_len_q[desc_idx_i]   <= desc_len_i;
        sh_rep_q[desc_idx_i]   <= desc_rep_i;
      end
      if (desc_commit_i) sh_nseg_q <= nseg_clamp;
      if (apply) begin
        for (int i = 0; i < NUM_SEG; i++) begin
          act_start_q[i] <= sh_start_q[i];
          act_len_q[i]   <= sh_len_q[i];
          act_rep_q[i]   <= sh_rep_q[i];
        end
        act_nseg_q <= sh_nseg_q;
      end
      pend_q <= pend_d;
    end
  end

  always_comb begin
    state_d = state_q;
    seg_d   = seg_q;
    rep_d   = rep_q;
    off_d   = off_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        seg_d = '0;
        rep_d = '0;
        off_d = '0;
        if (seq_en_i && act_nseg_q != '0) state_d = RUN;
      end
      RUN: begin
        if (!rd_go) begin
          state_d = IDLE;
          seg_d   = '0;
          rep_d   = '0;
          off_d   = '0;
        end else if (last_samp) begin
          off_d = '0;
          if (!last_rep) begin
            rep_d = rep_q + REP_WIDTH'(1);
          end else begin
            rep_d = '0;
            seg_d = last_seg ? '0 : seg_q + SW'(1);
            if (last_seg && !seq_loop_i) begin
              state_d = DONE;
              done_d  = 1'b1;
            end
          end
        end else begin
          off_d = off_q + ADDR_WIDTH'(1);
        end
      end
      DONE: begin
        seg_d = '0;
        rep_d = '0;
        off_d = '0;
        if (!seq_en_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      seg_q   <= '0;
      rep_q   <= '0;
      off_q   <= '0;
      done_q  <= 1'b0;
      v1_q    <= 1'b0;
      vld_q   <= 1'b0;
      ch0_q   <= '0;
      ch1_q   <= '0;
    end else begin
      state_q <= state_d;
      seg_q   <= seg_d;
      rep_q   <= rep_d;
      off_q   <= off_d;
      done_q  <= done_d;
      v1_q    <= mem_rd_en_o;
      vld_q   <= v1_q;
      // Hold through bubbles while running; blank once the pipe drains outside RUN
      if (v1_q) begin
        ch0_q <= smp.ch0;
        ch1_q <= smp.ch1;
      end else if (!run) begin
        ch0_q <= '0;
        ch1_q <= '0;
      end
    end
  end

`ifdef DAC_SEQ_LOOPCNT_EN
  logic [15:0] loop_cnt_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      loop_cnt_q <= '0;
    end else if (state_q == IDLE && state_d == RUN) begin
      loop_cnt_q <= '0;
    end else if (list_end && loop_cnt_q != 16'hFFFF) begin
      loop_cnt_q <= loop_cnt_q + 16'd1;
    end
  end
  assign loop_cnt_o = loop_cnt_q;
`endif

  assign mem_rd_en_o   = rd_go && (cur_len != '0);
  assign mem_addr_o    = run ? cur_start + off_q : '0;
  assign seg_idx_o     = seg_q;
  assign seq_busy_o    = run;
  assign seq_done_o    = done_q;
  assign commit_pend_o = pend_q;
  assign dac_ch0_o     = ch0_q;
  assign dac_ch1_o     = ch1_q;
  assign dac_valid_o   = vld_q;
endmodule

// File: tb/tb_dac_segment_sequencer.sv
// Directed per-cycle vector bench for dac_segment_sequencer with a BRAM model.
// BRAM word i holds ch1=i+100 and ch0=i.
module tb_dac_segment_sequencer;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        seq_en_i = 1'b0;
  logic        seq_loop_i = 1'b0;
  logic        desc_we_i = 1'b0;
  logic [1:0]  desc_idx_i = '0;
  logic [10:0] desc_start_i = '0;
  logic [10:0] desc_len_i = '0;
  logic [15:0] desc_rep_i = '0;
  logic [2:0]  desc_nseg_i = '0;
  logic        desc_commit_i = 1'b0;
  logic        commit_pend_o;
  logic [10:0] mem_addr_o;
  logic        mem_rd_en_o;
  logic [31:0] mem_data_i = '0;
  logic [13:0] dac_ch0_o, dac_ch1_o;
  logic        dac_valid_o;
  logic [1:0]  seg_idx_o;
  logic        seq_busy_o;
  logic        seq_done_o;

  dac_segment_sequencer dut (
    .clk(clk), .rst(rst),
    .seq_en_i(seq_en_i), .seq_loop_i(seq_loop_i),
    .desc_we_i(desc_we_i), .desc_idx_i(desc_idx_i),
    .desc_start_i(desc_start_i), .desc_len_i(desc_len_i),
    .desc_rep_i(desc_rep_i), .desc_nseg_i(desc_nseg_i),
    .desc_commit_i(desc_commit_i), .commit_pend_o(commit_pend_o),
    .mem_addr_o(mem_addr_o), .mem_rd_en_o(mem_rd_en_o),
    .mem_data_i(mem_data_i),
    .dac_ch0_o(dac_ch0_o), .dac_ch1_o(dac_ch1_o),
    .dac_valid_o(dac_valid_o), .seg_idx_o(seg_idx_o),
    .seq_busy_o(seq_busy_o), .seq_done_o(seq_done_o)
  );

  always #5 clk = ~clk;

  logic [31:0] bram [2048];
  initial begin
    for (int i = 0; i < 2048; i++)
      bram[i] = {2'b0, 14'(i + 100), 2'b0, 14'(i)};
  end
  always @(posedge clk)
    if (mem_rd_en_o) mem_data_i <= bram[mem_addr_o];

  typedef struct {
    bit en, we, cmt;
    bit rd;
    int addr, seg;
    bit vld;
    int ch;
    bit busy, done, pend;
  } vec_t;

  vec_t vq[$];
  int nvec = 0;
  int nbad = 0;
  int tno = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add(bit en, bit rd, int addr, int seg, bit vld, int ch,
                     bit busy, bit done = 0, bit we = 0, bit cmt = 0,
                     bit pend = 0);
    vec_t v;
    v.en = en; v.we = we; v.cmt = cmt; v.rd = rd; v.addr = addr;
    v.seg = seg; v.vld = vld; v.ch = ch; v.busy = busy; v.done = done;
    v.pend = pend;
    vq.push_back(v);
  endtask

  task automatic run_vecs();
    vec_t v;
    int e0, e1;
    for (int i = 0; i < vq.size(); i++) begin
      v = vq[i];
      seq_en_i = v.en;
      desc_we_i = v.we;
      desc_commit_i = v.cmt;
      @(negedge clk);
      e0 = (v.ch < 0) ? 0 : v.ch;
      e1 = (v.ch < 0) ? 0 : v.ch + 100;
      nvec++;
      if (mem_rd_en_o !== v.rd || mem_addr_o !== 11'(v.addr) ||
          seg_idx_o !== 2'(v.seg) || dac_valid_o !== v.vld ||
          dac_ch0_o !== 14'(e0) || dac_ch1_o !== 14'(e1) ||
          seq_busy_o !== v.busy || seq_done_o !== v.done ||
          commit_pend_o !== v.pend) begin
        nbad++;
        $display("FAIL t%0d c%0d: got rd=%0b addr=%0d seg=%0d vld=%0b ch0=%0d ch1=%0d busy=%0b done=%0b pend=%0b want rd=%0b addr=%0d seg=%0d vld=%0b ch0=%0d ch1=%0d busy=%0b done=%0b pend=%0b",
                 tno, i, mem_rd_en_o, mem_addr_o, seg_idx_o, dac_valid_o,
                 dac_ch0_o, dac_ch1_o, seq_busy_o, seq_done_o, commit_pend_o,
                 v.rd, v.addr, v.seg, v.vld, e0, e1, v.busy, v.done, v.pend);
      end
      @(posedge clk);
      #1;
    end
    vq.delete();
    seq_en_i = 0;
    desc_we_i = 0;
    desc_commit_i = 0;
    tno++;
  endtask

  task automatic do_reset();
    seq_en_i = 0;
    desc_we_i = 0;
    desc_commit_i = 0;
    rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    tick();
  endtask

  task automatic prog(int idx, int st, int ln, int rp);
    desc_idx_i = 2'(idx);
    desc_start_i = 11'(st);
    desc_len_i = 11'(ln);
    desc_rep_i = 16'(rp);
    desc_we_i = 1;
    tick();
    desc_we_i = 0;
  endtask

  task automatic commit(int n);
    desc_nseg_i = 3'(n);
    desc_commit_i = 1;
    tick();
    desc_commit_i = 0;
    tick();
  endtask

  initial begin
    // t0: reset state, empty bank never runs
    do_reset();
    add(1,0,0,0,0,-1,0);
    add(1,0,0,0,0,-1,0);
    add(1,0,0,0,0,-1,0);
    run_vecs();

    // t1: single looping segment, then enable drop and flush
    do_reset();
    prog(0, 0, 4, 0);
    commit(1);
    seq_loop_i = 1;
    add(1,0,0,0,0,-1,0);
    add(1,1,0,0,0,-1,1);
    add(1,1,1,0,0,-1,1);
    add(1,1,2,0,1,0,1);
    add(1,1,3,0,1,1,1);
    add(1,1,0,0,1,2,1);
    add(1,1,1,0,1,3,1);
    add(1,1,2,0,1,0,1);
    add(0,0,3,0,1,1,1);
    add(0,0,0,0,1,2,0);
    add(0,0,0,0,0,-1,0);
    run_vecs();

    // t2: repeats and segment boundary
    do_reset();
    prog(0, 0, 2, 2);
    prog(1, 10, 1, 0);
    commit(2);
    seq_loop_i = 1;
    add(1,0,0,0,0,-1,0);
    add(1,1,0,0,0,-1,1);
    add(1,1,1,0,0,-1,1);
    add(1,1,0,0,1,0,1);
    add(1,1,1,0,1,1,1);
    add(1,1,0,0,1,0,1);
    add(1,1,1,0,1,1,1);
    add(1,1,10,1,1,0,1);
    add(1,1,0,0,1,1,1);
    add(1,1,1,0,1,10,1);
    add(1,1,0,0,1,0,1);
    run_vecs();

    // reset mid-run with a commit pending
    seq_en_i = 1;
    repeat (5) tick();
    desc_commit_i = 1;
    tick();
    desc_commit_i = 0;
    rst = 1;
    #1;
    nvec++;
    if (seq_busy_o !== 0 || mem_rd_en_o !== 0 || dac_valid_o !== 0 ||
        dac_ch0_o !== 0 || dac_ch1_o !== 0 || commit_pend_o !== 0) begin
      nbad++;
      $display("FAIL rst_mid: busy=%0b rd=%0b vld=%0b ch0=%0d ch1=%0d pend=%0b want all 0",
               seq_busy_o, mem_rd_en_o, dac_valid_o, dac_ch0_o, dac_ch1_o,
               commit_pend_o);
    end
    @(posedge clk);
    #1 rst = 0;
    repeat (3) tick();
    nvec++;
    if (seq_busy_o !== 0 || mem_rd_en_o !== 0) begin
      nbad++;
      $display("FAIL rst_bank: busy=%0b rd=%0b want 0 0 (banks cleared)",
               seq_busy_o, mem_rd_en_o);
    end
    seq_en_i = 0;

    // t3: one-shot, done pulse, DONE held until enable drops
    do_reset();
    prog(0, 5, 3, 0);
    commit(1);
    seq_loop_i = 0;
    add(1,0,0,0,0,-1,0);
    add(1,1,5,0,0,-1,1);
    add(1,1,6,0,0,-1,1);
    add(1,1,7,0,1,5,1);
    add(1,0,0,0,1,6,0,1);
    add(1,0,0,0,1,7,0);
    add(1,0,0,0,0,-1,0);
    add(1,0,0,0,0,-1,0);
    add(0,0,0,0,0,-1,0);
    add(0,0,0,0,0,-1,0);
    run_vecs();

    // t4: zero-length segment bubble
    do_reset();
    prog(0, 0, 2, 0);
    prog(1, 30, 0, 0);
    prog(2, 40, 2, 0);
    commit(3);
    seq_loop_i = 1;
    add(1,0,0,0,0,-1,0);
    add(1,1,0,0,0,-1,1);
    add(1,1,1,0,0,-1,1);
    add(1,0,30,1,1,0,1);
    add(1,1,40,2,1,1,1);
    add(1,1,41,2,0,1,1);
    add(1,1,0,0,1,40,1);
    add(1,1,1,0,1,41,1);
    add(1,0,30,1,1,0,1);
    run_vecs();

    // t5: commit with write mid-run lands on list boundary
    do_reset();
    prog(0, 0, 2, 0);
    commit(1);
    seq_loop_i = 1;
    desc_idx_i = 0;
    desc_start_i = 20;
    desc_len_i = 2;
    desc_rep_i = 0;
    desc_nseg_i = 1;
    add(1,0,0,0,0,-1,0);
    add(1,1,0,0,0,-1,1,0,1,1,0);
    add(1,1,1,0,0,-1,1,0,0,0,1);
    add(1,1,20,0,1,0,1);
    add(1,1,21,0,1,1,1);
    add(1,1,20,0,1,20,1);
    add(1,1,21,0,1,21,1);
    run_vecs();

    // t6: address wrap, enable drop mid-segment
    do_reset();
    prog(0, 2046, 4, 0);
    commit(1);
    seq_loop_i = 1;
    add(1,0,0,0,0,-1,0);
    add(1,1,2046,0,0,-1,1);
    add(1,1,2047,0,0,-1,1);
    add(1,1,0,0,1,2046,1);
    add(0,0,1,0,1,2047,1);
    add(0,0,0,0,1,0,0);
    add(0,0,0,0,0,-1,0);
    run_vecs();

    // t7: segment count above NUM_SEG clamps
    do_reset();
    prog(0, 0, 1, 0);
    prog(1, 1, 1, 0);
    prog(2, 2, 1, 0);
    prog(3, 3, 1, 0);
    commit(7);
    seq_loop_i = 0;
    add(1,0,0,0,0,-1,0);
    add(1,1,0,0,0,-1,1);
    add(1,1,1,1,0,-1,1);
    add(1,1,2,2,1,0,1);
    add(1,1,3,3,1,1,1);
    add(1,0,0,0,1,2,0,1);
    add(1,0,0,0,1,3,0);
    run_vecs();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end
endmodule
